// File: rtl/target_spawner_if.sv
// Purpose : bundles the game-control inputs and display/score outputs of target_spawner.
// Latency : none, wires only.
// Backpress: none; every signal is a pulse or a level, with no handshake.
// Ports   : master = game controller/bench (drives start, ran_num, hit_valid, hit_idx);
//           slave  = target_spawner (drives active_mask, score, miss_count, pulses, game_over).
interface target_spawner_if #(
    parameter int NUM_TARGETS = 10
);
    logic                   start;
    logic [3:0]             ran_num;
    logic                   hit_valid;
    logic [3:0]             hit_idx;
    logic [NUM_TARGETS-1:0] active_mask;
    logic [31:0]            score;
    logic [7:0]             miss_count;
    logic                   hit_pulse;
    logic                   wrong_pulse;
    logic                   miss_pulse;
    logic                   game_over;

    modport master (
        output start, ran_num, hit_valid, hit_idx,
        input  active_mask, score, miss_count, hit_pulse, wrong_pulse, miss_pulse, game_over
    );

    modport slave (
        input  start, ran_num, hit_valid, hit_idx,
        output active_mask, score, miss_count, hit_pulse, wrong_pulse, miss_pulse, game_over
    );
endinterface

// File: rtl/target_spawner.sv
// Purpose : spawns targets from the RNG index on a fixed cadence, ages them, resolves hits, keeps score.
// Latency : every output is registered; an event sampled at edge N is visible right after edge N.
// Backpress: none; inputs are single-cycle pulses/levels and must be accepted every cycle.
// Ports   : clock, reset (async, active-high); bus (slave) carries start/ran_num/hit_valid/hit_idx in,
//           active_mask/score/miss_count/hit_pulse/wrong_pulse/miss_pulse/game_over out.
module target_spawner #(
    parameter int NUM_TARGETS  = 10,
    parameter int SPAWN_PERIOD = 25000000,
    parameter int LIFETIME     = 50000000,
    parameter int HIT_POINTS   = 10,
    parameter int PENALTY      = 5,
    parameter int SCORE_INIT   = 11,
    parameter int MAX_MISSES   = 8
) (
    input logic          clock,
    input logic          reset,
    target_spawner_if.slave bus
);
    localparam int SP_W = $clog2(SPAWN_PERIOD + 1);
    localparam int LT_W = $clog2(LIFETIME + 1);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t                 state, state_n;
    logic [SP_W-1:0]        spawn_cnt, spawn_cnt_n;
    logic [LT_W-1:0]        life   [NUM_TARGETS];
    logic [LT_W-1:0]        life_n [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] mask, mask_n;
    logic [31:0]            score, score_n;
    logic [7:0]             miss, miss_n;
    logic                   hit_p, hit_p_n;
    logic                   wrong_p, wrong_p_n;
    logic                   miss_p, miss_p_n;

    // Per-cycle event decode (only meaningful in RUN)
    logic                   wrap;
    logic [NUM_TARGETS-1:0] hit_lane;
    logic [NUM_TARGETS-1:0] expire;
    logic [NUM_TARGETS-1:0] spawn_lane;
    logic [8:0]             miss_sum;

    always_comb begin
        state_n     = state;
        spawn_cnt_n = spawn_cnt;
        life_n      = life;
        mask_n      = mask;
        score_n     = score;
        miss_n      = miss;
        hit_p_n     = 1'b0;
        wrong_p_n   = 1'b0;
        miss_p_n    = 1'b0;
        wrap        = 1'b0;
        hit_lane    = '0;
        expire      = '0;
        spawn_lane  = '0;
        miss_sum    = {1'b0, miss};

        if (bus.start) begin
            // Start wins over everything else that cycle, from any state.
            state_n     = RUN;
            spawn_cnt_n = '0;
            mask_n      = '0;
            score_n     = 32'(SCORE_INIT);
            miss_n      = '0;
            for (int i = 0; i < NUM_TARGETS; i++) life_n[i] = '0;
        end else if (state == RUN) begin
            wrap        = (spawn_cnt == SP_W'(SPAWN_PERIOD - 1));
            spawn_cnt_n = wrap ? '0 : spawn_cnt + 1'b1;

            // All decisions look at the mask as it stood at the start of the cycle.
            for (int i = 0; i < NUM_TARGETS; i++) begin
                hit_lane[i]   = bus.hit_valid && (bus.hit_idx == 4'(i)) && mask[i];
                // A hit on an expiring lane takes priority over the expiry.
                expire[i]     = mask[i] && (life[i] == LT_W'(LIFETIME - 1)) && !hit_lane[i];
                // Spawning onto a lit lane is skipped; illegal indices never match a lane.
                spawn_lane[i] = wrap && (bus.ran_num == 4'(i)) && !mask[i];
            end

            mask_n = (mask & ~hit_lane & ~expire) | spawn_lane;

            // Counters run only while a lane stays lit; fresh spawns and cleared lanes restart at 0.
            for (int i = 0; i < NUM_TARGETS; i++) begin
                life_n[i] = (mask[i] && mask_n[i]) ? life[i] + 1'b1 : '0;
                miss_sum  = miss_sum + 9'(expire[i]);
            end
            miss_n   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
            miss_p_n = |expire;

            if (bus.hit_valid) begin
                if (|hit_lane) begin
                    score_n = score + 32'(HIT_POINTS);
                    hit_p_n = 1'b1;
                end else begin
                    // Score is the RNG modulus, so it is floored at SCORE_INIT and never reaches 0.
                    score_n   = ({1'b0, score} < 33'(SCORE_INIT) + 33'(PENALTY)) ?
                                32'(SCORE_INIT) : score - 32'(PENALTY);
                    wrong_p_n = 1'b1;
                end
            end

            if (miss_sum >= 9'(MAX_MISSES)) begin
                state_n = OVER;
                mask_n  = '0;
                for (int i = 0; i < NUM_TARGETS; i++) life_n[i] = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            spawn_cnt <= '0;
            mask      <= '0;
            score     <= 32'(SCORE_INIT);
            miss      <= '0;
            hit_p     <= 1'b0;
            wrong_p   <= 1'b0;
            miss_p    <= 1'b0;
            for (int i = 0; i < NUM_TARGETS; i++) life[i] <= '0;
        end else begin
            state     <= state_n;
            spawn_cnt <= spawn_cnt_n;
            mask      <= mask_n;
            score     <= score_n;
            miss      <= miss_n;
            hit_p     <= hit_p_n;
            wrong_p   <= wrong_p_n;
            miss_p    <= miss_p_n;
            for (int i = 0; i < NUM_TARGETS; i++) life[i] <= life_n[i];
        end
    end

    assign bus.active_mask = mask;
    assign bus.score       = score;
    assign bus.miss_count  = miss;
    assign bus.hit_pulse   = hit_p;
    assign bus.wrong_pulse = wrong_p;
    assign bus.miss_pulse  = miss_p;
    assign bus.game_over   = (state == OVER);
endmodule

// File: tb/tb_target_spawner.sv
// Purpose : directed self-checking bench for target_spawner with short spawn/lifetime periods.
// Latency : outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Backpress: none.
module tb_target_spawner;
    localparam int NT  = 10;
    localparam int SP  = 4;
    localparam int LT  = 40;
    localparam int HP  = 10;
    localparam int PEN = 5;
    localparam int SI  = 11;
    localparam int MM  = 2;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    target_spawner_if #(.NUM_TARGETS(NT)) bus ();

    target_spawner #(
        .NUM_TARGETS (NT),
        .SPAWN_PERIOD(SP),
        .LIFETIME    (LT),
        .HIT_POINTS  (HP),
        .PENALTY     (PEN),
        .SCORE_INIT  (SI),
        .MAX_MISSES  (MM)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_hit(input logic [3:0] idx);
        bus.hit_valid = 1'b1;
        bus.hit_idx   = idx;
        step(1);
        bus.hit_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    // Present a lane index until it lights (bounded), then park the RNG on an illegal index.
    task automatic wait_lit(input int lane, input logic [3:0] rn);
        bus.ran_num = rn;
        for (int k = 0; k < 2 * SP && !bus.active_mask[lane]; k++) step(1);
        bus.ran_num = 4'd15;
        check_val("spawn_lit", 32'(bus.active_mask[lane]), 32'd1);
    endtask

    function automatic logic [31:0] pulses();
        return 32'({bus.hit_pulse, bus.wrong_pulse, bus.miss_pulse});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.ran_num   = 4'd3;
        bus.hit_valid = 1'b0;
        bus.hit_idx   = 4'd0;
        reset         = 1'b1;
        step(2);

        check_val("rst_mask",  32'(bus.active_mask), 32'h0);
        check_val("rst_score", bus.score, 32'd11);
        check_val("rst_miss",  32'(bus.miss_count), 32'd0);
        check_val("rst_over",  32'(bus.game_over), 32'd0);
        check_val("rst_pulse", pulses(), 32'd0);

        reset = 1'b0;
        step(1);
        pulse_hit(4'd7);
        check_val("idle_hit_pulse", pulses(), 32'd0);
        check_val("idle_hit_score", bus.score, 32'd11);

        // Spawn cadence: lane 3 lights after the 4th edge following start.
        bus.ran_num = 4'd3;
        pulse_start();
        check_val("start_over", 32'(bus.game_over), 32'd0);
        step(3);
        check_val("spawn_early", 32'(bus.active_mask), 32'h0);
        step(1);
        check_val("spawn_lane3", 32'(bus.active_mask), 32'h008);
        bus.ran_num = 4'd12;
        step(4);
        check_val("spawn_illegal", 32'(bus.active_mask), 32'h008);
        bus.ran_num = 4'd15;

        // Valid hit on lane 3.
        pulse_hit(4'd3);
        check_val("hit_mask",  32'(bus.active_mask), 32'h0);
        check_val("hit_score", bus.score, 32'd21);
        check_val("hit_pulse", pulses(), 32'b100);
        step(1);
        check_val("hit_pulse_end", pulses(), 32'd0);

        // Wrong hits and the score floor.
        pulse_hit(4'd7);
        check_val("wrong1_score", bus.score, 32'd16);
        check_val("wrong1_pulse", pulses(), 32'b010);
        pulse_hit(4'd7);
        check_val("wrong2_score", bus.score, 32'd11);
        pulse_hit(4'd7);
        check_val("floor_score", bus.score, 32'd11);
        check_val("floor_pulse", pulses(), 32'b010);
        pulse_hit(4'd12);
        check_val("illegal_hit_score", bus.score, 32'd11);
        check_val("illegal_hit_pulse", pulses(), 32'b010);
        step(1);
        check_val("wrong_pulse_end", pulses(), 32'd0);

        // Hit arriving on the expiry cycle wins.
        wait_lit(5, 4'd5);
        step(LT - 1);
        check_val("race_still_lit", 32'(bus.active_mask), 32'h020);
        pulse_hit(4'd5);
        check_val("race_score", bus.score, 32'd21);
        check_val("race_miss",  32'(bus.miss_count), 32'd0);
        check_val("race_pulse", pulses(), 32'b100);
        check_val("race_mask",  32'(bus.active_mask), 32'h0);

        // Two expiries end the game (lane 2 spawns exactly one period after lane 1).
        wait_lit(1, 4'd1);
        wait_lit(2, 4'd2);
        step(LT - SP);
        check_val("exp1_mask",  32'(bus.active_mask), 32'h004);
        check_val("exp1_miss",  32'(bus.miss_count), 32'd1);
        check_val("exp1_pulse", pulses(), 32'b001);
        check_val("exp1_over",  32'(bus.game_over), 32'd0);
        step(1);
        check_val("exp1_pulse_end", pulses(), 32'd0);
        step(SP - 1);
        check_val("over_flag",  32'(bus.game_over), 32'd1);
        check_val("over_miss",  32'(bus.miss_count), 32'd2);
        check_val("over_mask",  32'(bus.active_mask), 32'h0);
        check_val("over_score", bus.score, 32'd21);

        pulse_hit(4'd2);
        check_val("over_hit_score", bus.score, 32'd21);
        check_val("over_hit_pulse", pulses(), 32'd0);
        bus.ran_num = 4'd3;
        step(2 * SP);
        check_val("over_no_spawn", 32'(bus.active_mask), 32'h0);
        check_val("over_hold",     32'(bus.game_over), 32'd1);
        bus.ran_num = 4'd15;

        pulse_start();
        check_val("restart_over",  32'(bus.game_over), 32'd0);
        check_val("restart_score", bus.score, 32'd11);
        check_val("restart_miss",  32'(bus.miss_count), 32'd0);
        check_val("restart_mask",  32'(bus.active_mask), 32'h0);

        // Asynchronous reset mid-game with three lanes lit and a hit pulse showing.
        wait_lit(0, 4'd0);
        wait_lit(4, 4'd4);
        wait_lit(6, 4'd6);
        wait_lit(8, 4'd8);
        check_val("four_lit", 32'(bus.active_mask), 32'h151);
        pulse_hit(4'd8);
        check_val("pre_rst_score", bus.score, 32'd21);
        check_val("pre_rst_mask",  32'(bus.active_mask), 32'h051);
        #3;
        reset = 1'b1;
        #1;
        check_val("arst_mask",  32'(bus.active_mask), 32'h0);
        check_val("arst_score", bus.score, 32'd11);
        check_val("arst_pulse", pulses(), 32'd0);
        check_val("arst_over",  32'(bus.game_over), 32'd0);
        step(1);
        check_val("arst_edge_pulse", pulses(), 32'd0);
        reset       = 1'b0;
        bus.ran_num = 4'd3;
        pulse_hit(4'd0);
        check_val("post_rst_pulse", pulses(), 32'd0);
        step(SP);
        check_val("post_rst_idle_mask", 32'(bus.active_mask), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
